// File: rtl/cpu_mem_pkg.sv
// rtl/cpu_mem_pkg.sv - shared memory-access size encodings and store buffer entry type
// Purpose: size encodings common to the load-side extender and the store-side
//          aligner, plus the record held in each store buffer slot.
// Ports:   none (package).
package cpu_mem_pkg;

  localparam logic [1:0] SZ_WORD = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_BYTE = 2'd2;
  localparam logic [1:0] SZ_ILL  = 2'd3;

  // One queued store: word address (byte offset dropped), lane-placed data, lane enables.
  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } st_entry_t;

endpackage

// File: rtl/store_align_buffer_if.sv
// rtl/store_align_buffer_if.sv - store issue / memory drain bundle for the store align buffer
// Purpose: groups the store-request side, the memory-drain side and the status
//          outputs of store_align_buffer.
// Ports:   st_valid/st_ready/st_addr/st_data/st_size  store request handshake
//          mem_valid/mem_ready/mem_addr/mem_wdata/mem_be  memory drain handshake
//          misalign/bad_addr  rejected-request report; count  occupancy
//          slave modport = buffer view, master modport = issuing/consuming view.
interface store_align_buffer_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          st_valid;
  logic          st_ready;
  logic [31:0]   st_addr;
  logic [31:0]   st_data;
  logic [1:0]    st_size;
  logic          mem_valid;
  logic          mem_ready;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_be;
  logic          misalign;
  logic [31:0]   bad_addr;
  logic [CW-1:0] count;

  modport slave (
    input  st_valid, st_addr, st_data, st_size, mem_ready,
    output st_ready, mem_valid, mem_addr, mem_wdata, mem_be, misalign, bad_addr, count
  );

  modport master (
    output st_valid, st_addr, st_data, st_size, mem_ready,
    input  st_ready, mem_valid, mem_addr, mem_wdata, mem_be, misalign, bad_addr, count
  );

endinterface

// File: rtl/store_lane_align.sv
// rtl/store_lane_align.sv - places a store operand into byte lanes and checks alignment
// Purpose: combinational narrowing of a 32-bit register operand to word, half or
//          byte lanes of a data memory word.
// Ports:   offset (in, 2)  byte offset addr[1:0]
//          data   (in, 32) register operand
//          size   (in, 2)  SZ_WORD / SZ_HALF / SZ_BYTE / SZ_ILL
//          wdata  (out,32) lane-aligned data, unenabled lanes zero
//          be     (out,4)  byte enables, bit i = lane i
//          legal  (out,1)  naturally aligned and size encoding valid
module store_lane_align
  import cpu_mem_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [31:0] data,
  input  logic [1:0]  size,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic        legal
);

  always_comb begin
    wdata = '0;
    be    = '0;
    legal = 1'b0;
    case (size)
      SZ_WORD: begin
        legal = (offset == 2'b00);
        be    = 4'b1111;
        wdata = data;
      end
      SZ_HALF: begin
        legal = !offset[0];
        if (offset[1]) begin
          be    = 4'b1100;
          wdata = {data[15:0], 16'h0000};
        end else begin
          be    = 4'b0011;
          wdata = {16'h0000, data[15:0]};
        end
      end
      SZ_BYTE: begin
        legal = 1'b1;
        be    = 4'b0001 << offset;
        wdata = {24'h000000, data[7:0]} << {offset, 3'b000};
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/store_align_buffer.sv
// rtl/store_align_buffer.sv - aligns MEM-stage stores into lanes and queues them for data memory
// Purpose: accepts store requests, rejects misaligned/illegal ones with a one-cycle
//          misalign pulse, and drains aligned stores in FIFO order.
// Ports:   clk   (in)  rising-edge clock
//          reset (in)  asynchronous active-high reset
//          bus   (slave modport of store_align_buffer_if) request, drain and status signals
module store_align_buffer
  import cpu_mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  store_align_buffer_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          misalign_q, misalign_d;
  logic [31:0]   bad_addr_q, bad_addr_d;
  st_entry_t     storage_q [DEPTH];
  st_entry_t     storage_d [DEPTH];

  logic [31:0] al_wdata;
  logic [3:0]  al_be;
  logic        al_legal;
  logic        full, empty, accept, push, pop;
  st_entry_t   head;

  store_lane_align u_align (
    .offset (bus.st_addr[1:0]),
    .data   (bus.st_data),
    .size   (bus.st_size),
    .wdata  (al_wdata),
    .be     (al_be),
    .legal  (al_legal)
  );

  assign full   = (count_q == FULL_CNT);
  assign empty  = (count_q == '0);
  // Acceptance looks only at registered occupancy, so a pop never opens a
  // slot in the same cycle (no mem_ready -> st_ready path).
  assign accept = bus.st_valid && !full;
  assign push   = accept && al_legal;
  assign pop    = !empty && bus.mem_ready;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    storage_d  = storage_q;
    misalign_d = accept && !al_legal;
    bad_addr_d = bad_addr_q;

    if (accept && !al_legal) begin
      bad_addr_d = bus.st_addr;
    end
    if (push) begin
      storage_d[wr_ptr_q] = '{waddr: bus.st_addr[31:2], wdata: al_wdata, be: al_be};
      wr_ptr_d            = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      misalign_q <= 1'b0;
      bad_addr_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      misalign_q <= misalign_d;
      bad_addr_q <= bad_addr_d;
    end
  end

  // Payload storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    storage_q <= storage_d;
  end

  assign head = storage_q[rd_ptr_q];

  assign bus.st_ready  = !full;
  assign bus.mem_valid = !empty;
  assign bus.mem_addr  = empty ? 32'h0 : {head.waddr, 2'b00};
  assign bus.mem_wdata = empty ? 32'h0 : head.wdata;
  assign bus.mem_be    = empty ? 4'h0  : head.be;
  assign bus.misalign  = misalign_q;
  assign bus.bad_addr  = bad_addr_q;
  assign bus.count     = count_q;

endmodule

// File: tb/tb_store_align_buffer.sv
// tb/tb_store_align_buffer.sv - self-checking bench for store_align_buffer
module tb_store_align_buffer;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } ent_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  store_align_buffer_if #(.DEPTH(DEPTH)) bus ();

  store_align_buffer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  ent_t        mq[$];
  logic        m_mis = 1'b0;
  logic [31:0] m_bad = 32'h0;

  logic [105:0] obs;
  assign obs = {bus.st_ready, bus.mem_valid, bus.mem_addr, bus.mem_wdata, bus.mem_be,
                bus.misalign, bus.bad_addr, bus.count};

  function automatic logic [105:0] exp_vec();
    logic [31:0] a, w;
    logic [3:0]  b;
    a = 32'h0; w = 32'h0; b = 4'h0;
    if (mq.size() > 0) begin
      a = mq[0].addr; w = mq[0].wdata; b = mq[0].be;
    end
    return {(mq.size() < DEPTH), (mq.size() != 0), a, w, b, m_mis, m_bad, 3'(mq.size())};
  endfunction

  // Reference behaviour for one clock edge, from the store rules directly.
  task automatic model_edge(input bit v, input logic [31:0] a, input logic [31:0] d,
                            input logic [1:0] s, input bit mr);
    int   nbytes;
    int   off;
    bit   acc, legal;
    ent_t e;
    case (s)
      2'd0: nbytes = 4;
      2'd1: nbytes = 2;
      2'd2: nbytes = 1;
      default: nbytes = 0;
    endcase
    off   = int'(a % 4);
    acc   = v && (mq.size() < DEPTH);
    legal = (nbytes != 0) && ((a % nbytes) == 0);
    if (mq.size() > 0 && mr) void'(mq.pop_front());
    if (acc && legal) begin
      e.addr  = a - (a % 4);
      e.wdata = 32'((64'(d) & ((64'd1 << (8 * nbytes)) - 64'd1)) << (8 * off));
      e.be    = 4'(((1 << nbytes) - 1) << off);
      mq.push_back(e);
    end
    m_mis = acc && !legal;
    if (m_mis) m_bad = a;
  endtask

  task automatic step(input bit v, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] s, input bit mr);
    bus.st_valid  = v;
    bus.st_addr   = a;
    bus.st_data   = d;
    bus.st_size   = s;
    bus.mem_ready = mr;
    model_edge(v, a, d, s, mr);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.st_valid = 0; bus.st_addr = 0; bus.st_data = 0; bus.st_size = 0; bus.mem_ready = 0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    n_checks++;
    if (obs !== exp_vec()) $display("FAIL reset_vec got=%h exp=%h", obs, exp_vec());
    else n_pass++;
    n_checks++;
    if ({bus.st_ready, bus.mem_valid, bus.count} !== {1'b1, 1'b0, 3'd0})
      $display("FAIL reset_flags got=%b exp=%b", {bus.st_ready, bus.mem_valid, bus.count}, 5'b10000);
    else n_pass++;
  endtask

  task automatic test_lanes();
    step(1, 32'h1003, 32'h000000AB, 2'd2, 1);
    n_checks++;
    if ({bus.mem_valid, bus.mem_addr, bus.mem_be, bus.mem_wdata} !== {1'b1, 32'h1000, 4'b1000, 32'hAB000000})
      $display("FAIL sb_lane got=%h/%b/%h exp=1000/1000/ab000000", bus.mem_addr, bus.mem_be, bus.mem_wdata);
    else n_pass++;
    step(0, 0, 0, 0, 1);
    n_checks++;
    if (bus.mem_valid !== 1'b0) $display("FAIL sb_pop got=%b exp=0", bus.mem_valid);
    else n_pass++;
    step(1, 32'h2002, 32'h1234BEEF, 2'd1, 0);
    n_checks++;
    if ({bus.mem_be, bus.mem_wdata} !== {4'b1100, 32'hBEEF0000})
      $display("FAIL sh_lane got=%b/%h exp=1100/beef0000", bus.mem_be, bus.mem_wdata);
    else n_pass++;
    step(1, 32'h2004, 32'hCAFEF00D, 2'd0, 1);
    n_checks++;
    if ({bus.mem_addr, bus.mem_be, bus.mem_wdata} !== {32'h2004, 4'b1111, 32'hCAFEF00D})
      $display("FAIL sw_lane got=%h/%b/%h exp=2004/1111/cafef00d", bus.mem_addr, bus.mem_be, bus.mem_wdata);
    else n_pass++;
    step(0, 0, 0, 0, 1);
    n_checks++;
    if (obs !== exp_vec()) $display("FAIL lanes_drain got=%h exp=%h", obs, exp_vec());
    else n_pass++;
  endtask

  task automatic test_misalign();
    step(1, 32'h3001, 32'h11, 2'd1, 1);
    n_checks++;
    if ({bus.misalign, bus.bad_addr} !== {1'b1, 32'h3001})
      $display("FAIL mis_sh got=%b/%h exp=1/3001", bus.misalign, bus.bad_addr);
    else n_pass++;
    step(1, 32'h3002, 32'h22, 2'd0, 1);
    n_checks++;
    if ({bus.misalign, bus.bad_addr} !== {1'b1, 32'h3002})
      $display("FAIL mis_sw got=%b/%h exp=1/3002", bus.misalign, bus.bad_addr);
    else n_pass++;
    step(1, 32'h3000, 32'h33, 2'd3, 1);
    n_checks++;
    if ({bus.misalign, bus.bad_addr, bus.count, bus.mem_valid} !== {1'b1, 32'h3000, 3'd0, 1'b0})
      $display("FAIL mis_ill got=%b/%h/%0d/%b exp=1/3000/0/0", bus.misalign, bus.bad_addr, bus.count, bus.mem_valid);
    else n_pass++;
    step(0, 0, 0, 0, 1);
    n_checks++;
    if ({bus.misalign, bus.bad_addr} !== {1'b0, 32'h3000})
      $display("FAIL mis_end got=%b/%h exp=0/3000", bus.misalign, bus.bad_addr);
    else n_pass++;
  endtask

  task automatic test_full();
    for (int k = 0; k < 4; k++) step(1, 32'h4000 + 32'(4 * k), 32'hD0 + 32'(k), 2'd0, 0);
    n_checks++;
    if ({bus.count, bus.st_ready} !== {3'd4, 1'b0})
      $display("FAIL full_cnt got=%0d/%b exp=4/0", bus.count, bus.st_ready);
    else n_pass++;
    // Fifth store, illegal on purpose: offered while full it must not pulse misalign.
    step(1, 32'h4011, 32'hEE, 2'd0, 0);
    n_checks++;
    if (obs !== exp_vec() || bus.misalign !== 1'b0)
      $display("FAIL full_ill got=%h exp=%h", obs, exp_vec());
    else n_pass++;
    step(1, 32'h4010, 32'hD4, 2'd0, 1);
    n_checks++;
    if (obs !== exp_vec() || bus.count !== 3'd3)
      $display("FAIL full_pop1 got=%h exp=%h", obs, exp_vec());
    else n_pass++;
    step(1, 32'h4010, 32'hD4, 2'd0, 1);
    n_checks++;
    if (obs !== exp_vec() || bus.count !== 3'd3)
      $display("FAIL full_acc5 got=%h exp=%h", obs, exp_vec());
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 0, 1);
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL full_drain k=%0d got=%h exp=%h", k, obs, exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) begin
      step(1, 32'h5000 + 32'(4 * i), $urandom, 2'd0, 1);
      n_checks++;
      if (obs !== exp_vec() || bus.count !== 3'd1)
        $display("FAIL b2b i=%0d got=%h exp=%h", i, obs, exp_vec());
      else n_pass++;
    end
    step(0, 0, 0, 0, 1);
    n_checks++;
    if (obs !== exp_vec()) $display("FAIL b2b_end got=%h exp=%h", obs, exp_vec());
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 3) != 0, $urandom, $urandom, 2'($urandom_range(0, 3)),
           $urandom_range(0, 2) != 0);
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL rand cyc=%0d got=%h exp=%h", i, obs, exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    while (mq.size() > 0) step(0, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) step(1, 32'h6000 + 32'(4 * k), 32'h60 + 32'(k), 2'd0, 0);
    n_checks++;
    if (bus.count !== 3'd3) $display("FAIL ar_pre got=%0d exp=3", bus.count);
    else n_pass++;
    bus.st_valid = 0;
    #3;
    reset = 1'b1;
    #1;
    mq.delete();
    m_mis = 1'b0;
    m_bad = 32'h0;
    n_checks++;
    if ({bus.count, bus.mem_valid, bus.st_ready, bus.misalign} !== {3'd0, 1'b0, 1'b1, 1'b0})
      $display("FAIL ar_now got=%0d/%b/%b/%b exp=0/0/1/0", bus.count, bus.mem_valid, bus.st_ready, bus.misalign);
    else n_pass++;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0, 1);
      n_checks++;
      if (obs !== exp_vec() || bus.mem_valid !== 1'b0)
        $display("FAIL ar_post k=%0d got=%h exp=%h", k, obs, exp_vec());
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_lanes();
    test_misalign();
    test_full();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/store_align_buffer.md
Name: store_align_buffer

Overview:
- Store-side counterpart of the load/immediate extension path: narrows a 32-bit register operand to byte, halfword or word lanes of data memory.
- Sits between the MEM-stage store issue and the data memory port.
- Computes word address, lane-aligned write data and byte enables; flags misaligned stores.
- Buffers accepted stores in a small FIFO and drains them over a valid/ready handshake.

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2.
- CW, $clog2(DEPTH)+1, width of occupancy count (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- st_valid  in  1  store request present.
- st_ready  out  1  buffer can accept; equals !full.
- st_addr  in  32  byte address.
- st_data  in  32  register data; low bits significant for narrow stores.
- st_size  in  2  0=word (SW), 1=half (SH), 2=byte (SB), 3=illegal.
- mem_valid  out  1  head entry valid; equals !empty.
- mem_ready  in  1  memory accepts head entry.
- mem_addr  out  32  word address {st_addr[31:2],2'b00}.
- mem_wdata  out  32  lane-aligned write data.
- mem_be  out  4  byte enables, bit i = byte lane i.
- misalign  out  1  one-cycle pulse: last offered request rejected.
- bad_addr  out  32  address of most recent rejected request.
- count  out  CW  current occupancy.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high, on ports clk and reset.
- Reset values: count=0, read/write pointers=0, mem_valid=0, st_ready=1, misalign=0, bad_addr=0. mem_addr, mem_wdata and mem_be read 0 while empty. FIFO storage is not reset.
- Reset mid-operation: all queued entries are discarded; no partial drain.
- Push condition: st_valid && st_ready && legal.
- Legal request:
  - size 0 with addr[1:0]==0.
  - size 1 with addr[0]==0.
  - size 2, any address.
- Illegal request (misaligned, or size 3) when st_valid && st_ready:
  - not enqueued.
  - misalign=1 on the following cycle, for exactly one cycle.
  - bad_addr<=st_addr.
  - Back-to-back illegal requests keep misalign high on consecutive cycles.
- Offered while full: no push, no misalign, even if the request is illegal (not accepted).
- Lane alignment (o = addr[1:0]):
  - Word: be=4'b1111, wdata=st_data.
  - Half: be = o[1] ? 4'b1100 : 4'b0011; data[15:0] placed in lanes {o[1],1}..{o[1],0}.
  - Byte: be = 4'b0001<<o; data[7:0] placed in lane o.
  - Unenabled lanes are 0.
- Pop: mem_valid && mem_ready. Head advances at that edge.
- Latency: a store accepted at edge N has mem_valid=1 after edge N. The earliest pop is edge N+1. No same-cycle bypass.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Full: count==DEPTH, so st_ready=0. Full with pop frees a slot for the next cycle only (st_ready is not combinationally tied to mem_ready).
- Empty: mem_valid=0; mem_ready is ignored.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally; ordering is strictly FIFO.
- mem_* outputs are driven from registered head storage (no combinational path from st_* to mem_*).

Decomposition:
- Shared package cpu_mem_pkg:
  - SZ_WORD=2'd0, SZ_HALF=2'd1, SZ_BYTE=2'd2, SZ_ILL=2'd3.
  - The same encodings are used by the load-side extender.
- One combinational sub-module, store_lane_align: (addr[1:0], data, size) → (wdata, be, legal). Instantiated once at the push side.
- FIFO control stays in the top module.

Test Plan:
- SB, addr=0x1003, data=0x000000AB, mem_ready=1 → next cycle mem_addr=0x1000, mem_be=4'b1000, mem_wdata=0xAB000000; popped the cycle after.
- SH, addr=0x2002, data=0x1234BEEF → mem_be=4'b1100, mem_wdata=0xBEEF0000. Then SW, addr=0x2004, data=0xCAFEF00D → be=4'b1111, wdata unchanged.
- SH addr=0x3001, then SW addr=0x3002, then size=3 addr=0x3000 → misalign high 3 consecutive cycles; bad_addr ends at 0x3000; count stays 0; mem_valid never rises.
- mem_ready=0, push 5 legal SWs (DEPTH=4) → count=4, st_ready=0 after the 4th; 5th held. Raise mem_ready → entries drain in order, 5th accepted one cycle after the first pop.
- Continuous push and pop at full throughput for 10 stores → count constant at 1; output order matches input; pointers wrap without loss.
- Assert reset asynchronously (mid-clock) with count=3 → immediately count=0, mem_valid=0, st_ready=1, misalign=0; no stale entry emitted after reset release.
